// File: rtl/fb_pkg.sv
// fb_pkg: frame-buffer geometry and word/pixel types shared by VGA, draw and arbiter blocks
package fb_pkg;
    localparam int ADDR_W = 17;
    localparam int PIX_W = 8;
    localparam int PIX_PER_WORD = 4;
    localparam int FB_WORDS = 76800;
    localparam int WORD_W = PIX_W * PIX_PER_WORD;
    localparam int IDX_W = $clog2(PIX_PER_WORD);
    typedef logic [WORD_W-1:0] word_t;
    typedef logic [PIX_W-1:0] pix_t;
    typedef logic [ADDR_W-1:0] addr_t;
endpackage

// File: rtl/fb_arbiter_if.sv
// fb_arbiter_if: pixel, draw and RAM signals of the frame-buffer arbiter
interface fb_arbiter_if;
    import fb_pkg::*;
    logic frame_start;
    logic pix_ready;
    pix_t pix_data;
    logic pix_valid;
    logic wr_valid;
    addr_t wr_addr;
    word_t wr_data;
    logic wr_ready;
    addr_t mem_addr;
    logic mem_we;
    word_t mem_wdata;
    word_t mem_rdata;
    logic underrun;
    modport master (
        input frame_start, pix_ready, wr_valid, wr_addr, wr_data, mem_rdata,
        output pix_data, pix_valid, wr_ready, mem_addr, mem_we, mem_wdata, underrun
    );
    modport slave (
        output frame_start, pix_ready, wr_valid, wr_addr, wr_data, mem_rdata,
        input pix_data, pix_valid, wr_ready, mem_addr, mem_we, mem_wdata, underrun
    );
endinterface

// File: rtl/fb_word_fifo.sv
// fb_word_fifo: small prefetch word buffer with flush and occupancy count
module fb_word_fifo import fb_pkg::*; #(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic flush,
    input  logic push,
    input  logic pop,
    input  word_t din,
    output word_t head,
    output logic [$clog2(DEPTH):0] cnt
);
    localparam int PW = $clog2(DEPTH);
    word_t mem [DEPTH];
    logic [PW-1:0] wp, rp;
    assign head = mem[rp];
    always_ff @(posedge clk) begin
        if (push)
            mem[wp] <= din;
    end
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wp <= '0;
            rp <= '0;
            cnt <= '0;
        end else begin
            if (push)
                wp <= wp + 1'b1;
            if (pop)
                rp <= rp + 1'b1;
            cnt <= cnt + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
        end
    end
endmodule

// File: rtl/fb_arbiter.sv
// fb_arbiter: shares one frame-buffer RAM port between prefetching scanout and the draw port
module fb_arbiter import fb_pkg::*; #(
    parameter int FB_WORDS = fb_pkg::FB_WORDS,
    parameter int BUF_WORDS = 2
) (
    input logic pll_clk,
    input logic reset_P,
    fb_arbiter_if.master bus
);
    localparam int CNT_W = $clog2(BUF_WORDS) + 1;
    addr_t scan_addr;
    logic [IDX_W-1:0] idx;
    logic [CNT_W-1:0] cnt;
    word_t head;
    logic rd_pend, rd_tag, epoch;
    logic rd_req, push, pop_pix, pop_word;

    fb_word_fifo #(.DEPTH(BUF_WORDS)) u_fifo (
        .clk(pll_clk),
        .rst(reset_P),
        .flush(bus.frame_start),
        .push(push),
        .pop(pop_word),
        .din(bus.mem_rdata),
        .head(head),
        .cnt(cnt)
    );

    // a return whose epoch tag predates the latest frame_start belongs to the old frame
    always_comb begin
        rd_req = !reset_P && (int'(cnt) + int'(rd_pend) < BUF_WORDS);
        push = rd_pend && rd_tag == epoch;
        bus.pix_valid = cnt != '0;
        pop_pix = bus.pix_ready && bus.pix_valid;
        pop_word = pop_pix && idx == IDX_W'(PIX_PER_WORD - 1);
        bus.pix_data = bus.pix_valid ? head[idx * PIX_W +: PIX_W] : '0;
        bus.wr_ready = !reset_P && !rd_req && bus.wr_valid;
        bus.mem_we = bus.wr_ready;
        bus.mem_addr = rd_req ? scan_addr : bus.wr_ready ? bus.wr_addr : '0;
        bus.mem_wdata = bus.wr_ready ? bus.wr_data : '0;
    end

    always_ff @(posedge pll_clk) begin
        if (reset_P) begin
            scan_addr <= '0;
            idx <= '0;
            rd_pend <= 1'b0;
            rd_tag <= 1'b0;
            epoch <= 1'b0;
            bus.underrun <= 1'b0;
        end else begin
            rd_pend <= rd_req;
            rd_tag <= epoch;
            bus.underrun <= bus.underrun | (bus.pix_ready & ~bus.pix_valid);
            if (bus.frame_start) begin
                epoch <= ~epoch;
                scan_addr <= '0;
                idx <= '0;
            end else begin
                if (rd_req)
                    scan_addr <= scan_addr == ADDR_W'(FB_WORDS - 1) ? '0 : scan_addr + 1'b1;
                if (pop_pix)
                    idx <= idx + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_fb_arbiter.sv
// tb_fb_arbiter: directed checks of scan prefetch, draw arbitration, frame restart and underrun
module tb_fb_arbiter;
    import fb_pkg::*;
    logic pll_clk = 1'b0;
    logic reset_P = 1'b1;
    logic rst8 = 1'b1;
    int checks = 0;
    int errors = 0;

    fb_arbiter_if bus();
    fb_arbiter_if b8();

    fb_arbiter dut (.pll_clk(pll_clk), .reset_P(reset_P), .bus(bus));
    fb_arbiter #(.FB_WORDS(8)) dut8 (.pll_clk(pll_clk), .reset_P(rst8), .bus(b8));

    always #5 pll_clk = ~pll_clk;

    function automatic word_t word_of(addr_t a);
        return a == '0 ? 32'h44332211 : {4{a[7:0]}};
    endfunction

    function automatic pix_t exp_pix(int k);
        word_t w = word_of(addr_t'(k / 4));
        return w[8 * (k % 4) +: 8];
    endfunction

    // one-cycle-latency RAM models
    always @(posedge pll_clk) begin
        bus.mem_rdata <= word_of(bus.mem_addr);
        b8.mem_rdata <= {4{8'hA0 | b8.mem_addr[7:0]}};
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        int rd_cnt;
        int wr_cnt;
        int e;
        addr_t exp_a;
        bus.frame_start = 1'b0;
        bus.pix_ready = 1'b0;
        bus.wr_valid = 1'b1;
        bus.wr_addr = 17'h155;
        bus.wr_data = 32'hCAFEF00D;
        b8.frame_start = 1'b0;
        b8.pix_ready = 1'b0;
        b8.wr_valid = 1'b0;
        b8.wr_addr = '0;
        b8.wr_data = '0;
        repeat (3) @(negedge pll_clk);
        #1;
        chk("rst_pix_valid", bus.pix_valid, 0);
        chk("rst_pix_data", bus.pix_data, 0);
        chk("rst_wr_ready", bus.wr_ready, 0);
        chk("rst_mem_we", bus.mem_we, 0);
        chk("rst_mem_addr", bus.mem_addr, 0);
        chk("rst_mem_wdata", bus.mem_wdata, 0);
        chk("rst_underrun", bus.underrun, 0);
        @(negedge pll_clk);

        // idle prefetch: two reads, then stop
        reset_P = 1'b0;
        bus.wr_valid = 1'b0;
        #1;
        chk("t1_rd0_addr", bus.mem_addr, 0);
        chk("t1_rd0_we", bus.mem_we, 0);
        @(negedge pll_clk);
        #1;
        chk("t1_rd1_addr", bus.mem_addr, 1);
        rd_cnt = 0;
        repeat (18) begin
            @(negedge pll_clk);
            #1;
            if (bus.mem_addr != '0) rd_cnt++;
        end
        chk("t1_extra_reads", rd_cnt, 0);
        chk("t1_pix_valid", bus.pix_valid, 1);
        chk("t1_pix_data", bus.pix_data, 8'h11);
        @(negedge pll_clk);

        // continuous scanout
        rd_cnt = 0;
        exp_a = 2;
        bus.pix_ready = 1'b1;
        for (int j = 0; j < 64; j++) begin
            #1;
            chk("t2_pix", bus.pix_data, exp_pix(j));
            if (bus.mem_addr != '0) begin
                rd_cnt++;
                chk("t2_rd_addr", bus.mem_addr, exp_a);
                exp_a++;
            end
            @(negedge pll_clk);
        end
        chk("t2_reads", rd_cnt, 15);
        chk("t2_underrun", bus.underrun, 0);

        // draw port shares the remaining cycles
        wr_cnt = 0;
        bus.wr_valid = 1'b1;
        bus.wr_addr = 17'h100;
        bus.wr_data = 32'hDEADBEEF;
        for (int j = 64; j < 80; j++) begin
            #1;
            chk("t3_pix", bus.pix_data, exp_pix(j));
            if (bus.wr_ready) begin
                wr_cnt++;
                chk("t3_wr_we", bus.mem_we, 1);
                chk("t3_wr_addr", bus.mem_addr, 17'h100);
                chk("t3_wr_data", bus.mem_wdata, 32'hDEADBEEF);
            end else begin
                chk("t3_rd_we", bus.mem_we, 0);
                chk("t3_rd_addr", bus.mem_addr, exp_a);
                exp_a++;
            end
            @(negedge pll_clk);
        end
        chk("t3_wr_count", wr_cnt, 12);

        // frame restart, then discard of a read issued with frame_start
        bus.wr_valid = 1'b0;
        bus.pix_ready = 1'b0;
        bus.frame_start = 1'b1;
        @(negedge pll_clk);
        bus.frame_start = 1'b0;
        repeat (5) @(negedge pll_clk);
        #1;
        chk("t4_refill_valid", bus.pix_valid, 1);
        chk("t4_refill_pix", bus.pix_data, 8'h11);
        bus.pix_ready = 1'b1;
        for (int c = 0; c < 32; c++) begin
            #1;
            chk("t4_pix", bus.pix_data, exp_pix(c));
            @(negedge pll_clk);
        end
        bus.pix_ready = 1'b0;
        bus.frame_start = 1'b1;
        #1;
        chk("t4_rd9_addr", bus.mem_addr, 9);
        @(negedge pll_clk);
        bus.frame_start = 1'b0;
        #1;
        chk("t4_restart_addr0", bus.mem_addr, 0);
        chk("t4_flushed", bus.pix_valid, 0);
        @(negedge pll_clk);
        #1;
        chk("t4_restart_addr1", bus.mem_addr, 1);
        @(negedge pll_clk);
        #1;
        chk("t4_first_valid", bus.pix_valid, 1);
        chk("t4_first_pix", bus.pix_data, 8'h11);
        @(negedge pll_clk);

        // short frame wrap on the FB_WORDS=8 instance
        rst8 = 1'b0;
        repeat (5) @(negedge pll_clk);
        b8.pix_ready = 1'b1;
        for (int j = 0; j < 36; j++) begin
            #1;
            if (j >= 20 && j % 4 == 0) begin
                e = j == 20 ? 6 : j == 24 ? 7 : j == 28 ? 0 : 1;
                chk("t5_wrap_addr", b8.mem_addr, e);
            end
            if (j >= 28)
                chk("t5_wrap_pix", b8.pix_data, 8'hA0 | ((j / 4) % 8));
            @(negedge pll_clk);
        end
        b8.pix_ready = 1'b0;

        // reset mid-operation, then sticky underrun
        reset_P = 1'b1;
        bus.wr_valid = 1'b1;
        @(negedge pll_clk);
        #1;
        chk("t6_rst_valid", bus.pix_valid, 0);
        chk("t6_rst_pix", bus.pix_data, 0);
        chk("t6_rst_mem_addr", bus.mem_addr, 0);
        chk("t6_rst_wr_ready", bus.wr_ready, 0);
        @(negedge pll_clk);
        reset_P = 1'b0;
        bus.wr_valid = 1'b0;
        bus.pix_ready = 1'b1;
        #1;
        chk("t6_empty_pix", bus.pix_data, 0);
        chk("t6_empty_valid", bus.pix_valid, 0);
        @(negedge pll_clk);
        bus.pix_ready = 1'b0;
        #1;
        chk("t6_underrun_set", bus.underrun, 1);
        @(negedge pll_clk);
        bus.frame_start = 1'b1;
        @(negedge pll_clk);
        bus.frame_start = 1'b0;
        #1;
        chk("t6_underrun_sticky", bus.underrun, 1);
        @(negedge pll_clk);
        reset_P = 1'b1;
        @(negedge pll_clk);
        #1;
        chk("t6_underrun_cleared", bus.underrun, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
